// File: rtl/bingo_board_writer.sv
// Builds the 5x5 Bingo board: loads 25 cells, marks called numbers by a 25-cycle scan, then recounts lines.
// A call completes 26 edges after acceptance; call_ready stays low while busy and after a win.
module bingo_board_writer #(
  parameter int WIN_LINES = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load_valid,
  input  logic [4:0]   load_num,
  output logic         load_ready,
  input  logic         call_valid,
  input  logic [4:0]   call_num,
  output logic         call_ready,
  output logic         call_done,
  output logic         call_hit,
  output logic [124:0] map,
  output logic [24:0]  circle,
  output logic [3:0]   line_cnt,
  output logic [7:0]   display_nums,
  output logic         board_ready,
  output logic         win
);

  typedef enum logic [1:0] {LOAD, PLAY, SCAN, COUNT} state_t;

  state_t         state_q, state_d;
  logic [124:0]   map_q, map_d;
  logic [24:0]    circle_q, circle_d;
  logic [3:0]     line_cnt_q, line_cnt_d;
  logic [7:0]     disp_q, disp_d;
  logic [4:0]     ptr_q, ptr_d;
  logic [4:0]     idx_q, idx_d;
  logic [4:0]     num_q, num_d;
  logic           hit_q, hit_d;
  logic           call_done_q, call_done_d;
  logic           call_hit_q, call_hit_d;
  logic           board_ready_q, board_ready_d;
  logic           win_q, win_d;
  logic           load_ready_q, load_ready_d;
  logic           call_ready_q, call_ready_d;
  logic [3:0]     cnt_new;

  function automatic logic [3:0] count_lines(input logic [24:0] c);
    logic [3:0] n;
    n = 4'd0;
    for (int k = 0; k < 5; k++) begin
      if (&c[5*k +: 5]) n = n + 4'd1;
      if (c[k] && c[k+5] && c[k+10] && c[k+15] && c[k+20]) n = n + 4'd1;
    end
    if (c[0] && c[6] && c[12] && c[18] && c[24]) n = n + 4'd1;
    if (c[4] && c[8] && c[12] && c[16] && c[20]) n = n + 4'd1;
    return n;
  endfunction

  always_comb begin
    state_d       = state_q;
    map_d         = map_q;
    circle_d      = circle_q;
    line_cnt_d    = line_cnt_q;
    disp_d        = disp_q;
    ptr_d         = ptr_q;
    idx_d         = idx_q;
    num_d         = num_q;
    hit_d         = hit_q;
    call_done_d   = 1'b0;
    call_hit_d    = call_hit_q;
    board_ready_d = board_ready_q;
    win_d         = win_q;
    cnt_new       = count_lines(circle_q);

    case (state_q)
      LOAD: begin
        if (load_valid && load_num >= 5'd1 && load_num <= 5'd25) begin
          map_d[7'(ptr_q) * 7'd5 +: 5] = load_num;
          ptr_d = ptr_q + 5'd1;
          if (ptr_q == 5'd24) begin
            state_d       = PLAY;
            board_ready_d = 1'b1;
          end
        end
      end
      PLAY: begin
        if (call_valid && call_ready_q) begin
          num_d   = call_num;
          hit_d   = 1'b0;
          idx_d   = 5'd0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        // Cells are 1..25 once loaded, so out-of-range calls never match.
        if (map_q[7'(idx_q) * 7'd5 +: 5] == num_q) begin
          circle_d[idx_q] = 1'b1;
          hit_d           = 1'b1;
        end
        if (idx_q == 5'd24) state_d = COUNT;
        else                idx_d   = idx_q + 5'd1;
      end
      COUNT: begin
        line_cnt_d  = cnt_new;
        disp_d      = (cnt_new >= 4'd10) ? {4'd1, cnt_new - 4'd10} : {4'd0, cnt_new};
        if (32'(cnt_new) >= WIN_LINES) win_d = 1'b1;
        call_done_d = 1'b1;
        call_hit_d  = hit_q;
        state_d     = PLAY;
      end
      default: state_d = LOAD;
    endcase

    if (clear) begin
      state_d       = LOAD;
      map_d         = '0;
      circle_d      = '0;
      line_cnt_d    = '0;
      disp_d        = '0;
      ptr_d         = '0;
      idx_d         = '0;
      num_d         = '0;
      hit_d         = 1'b0;
      call_done_d   = 1'b0;
      call_hit_d    = 1'b0;
      board_ready_d = 1'b0;
      win_d         = 1'b0;
    end

    load_ready_d = (state_d == LOAD);
    call_ready_d = (state_d == PLAY) && !win_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= LOAD;
      map_q         <= '0;
      circle_q      <= '0;
      line_cnt_q    <= '0;
      disp_q        <= '0;
      ptr_q         <= '0;
      idx_q         <= '0;
      num_q         <= '0;
      hit_q         <= 1'b0;
      call_done_q   <= 1'b0;
      call_hit_q    <= 1'b0;
      board_ready_q <= 1'b0;
      win_q         <= 1'b0;
      load_ready_q  <= 1'b1;
      call_ready_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      map_q         <= map_d;
      circle_q      <= circle_d;
      line_cnt_q    <= line_cnt_d;
      disp_q        <= disp_d;
      ptr_q         <= ptr_d;
      idx_q         <= idx_d;
      num_q         <= num_d;
      hit_q         <= hit_d;
      call_done_q   <= call_done_d;
      call_hit_q    <= call_hit_d;
      board_ready_q <= board_ready_d;
      win_q         <= win_d;
      load_ready_q  <= load_ready_d;
      call_ready_q  <= call_ready_d;
    end
  end

  assign load_ready   = load_ready_q;
  assign call_ready   = call_ready_q;
  assign call_done    = call_done_q;
  assign call_hit     = call_hit_q;
  assign map          = map_q;
  assign circle       = circle_q;
  assign line_cnt     = line_cnt_q;
  assign display_nums = disp_q;
  assign board_ready  = board_ready_q;
  assign win          = win_q;

endmodule

// File: tb/tb_bingo_board_writer.sv
// Scoreboard bench: two boards share stimulus, one never wins (WIN_LINES=13), one wins at 5 lines.
module tb_bingo_board_writer;

  logic clk = 1'b0;
  logic rst, clear, load_valid, call_valid;
  logic [4:0] load_num, call_num;

  logic         load_ready_a, call_ready_a, call_done_a, call_hit_a, board_ready_a, win_a;
  logic [124:0] map_a;
  logic [24:0]  circle_a;
  logic [3:0]   line_cnt_a;
  logic [7:0]   disp_a;
  logic         load_ready_b, call_ready_b, call_done_b, call_hit_b, board_ready_b, win_b;
  logic [124:0] map_b;
  logic [24:0]  circle_b;
  logic [3:0]   line_cnt_b;
  logic [7:0]   disp_b;

  bingo_board_writer #(.WIN_LINES(13)) dut_a (
    .clk(clk), .rst(rst), .clear(clear),
    .load_valid(load_valid), .load_num(load_num), .load_ready(load_ready_a),
    .call_valid(call_valid), .call_num(call_num), .call_ready(call_ready_a),
    .call_done(call_done_a), .call_hit(call_hit_a), .map(map_a), .circle(circle_a),
    .line_cnt(line_cnt_a), .display_nums(disp_a), .board_ready(board_ready_a), .win(win_a)
  );

  bingo_board_writer #(.WIN_LINES(5)) dut_b (
    .clk(clk), .rst(rst), .clear(clear),
    .load_valid(load_valid), .load_num(load_num), .load_ready(load_ready_b),
    .call_valid(call_valid), .call_num(call_num), .call_ready(call_ready_b),
    .call_done(call_done_b), .call_hit(call_hit_b), .map(map_b), .circle(circle_b),
    .line_cnt(line_cnt_b), .display_nums(disp_b), .board_ready(board_ready_b), .win(win_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [24:0] circle;
    logic        hit;
    logic [3:0]  lines;
    logic [7:0]  disp;
    logic        win;
    int          done_cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  // Lines completed after calling 1..k on the board where cell i holds i+1.
  int lines_tab [0:25] = '{0,0,0,0,0, 1,1,1,1,1, 2,2,2,2,2, 3,3,3,3,3, 4,6,7,8,9,12};
  logic [124:0] map_exp;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] bcd8(input logic [3:0] v);
    return (v >= 4'd10) ? {4'd1, v - 4'd10} : {4'd0, v};
  endfunction

  always @(negedge clk) begin
    if (rst && call_done_a) begin
      if (qa.size() == 0) chk("a_unexpected_done", call_done_a, 1'b0);
      else begin
        ea = qa.pop_front();
        chk("a_circle", circle_a, ea.circle);
        chk("a_hit", call_hit_a, ea.hit);
        chk("a_line_cnt", line_cnt_a, ea.lines);
        chk("a_display", disp_a, ea.disp);
        chk("a_win", win_a, ea.win);
        chk("a_latency", cyc, ea.done_cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (rst && call_done_b) begin
      if (qb.size() == 0) chk("b_unexpected_done", call_done_b, 1'b0);
      else begin
        eb = qb.pop_front();
        chk("b_circle", circle_b, eb.circle);
        chk("b_hit", call_hit_b, eb.hit);
        chk("b_line_cnt", line_cnt_b, eb.lines);
        chk("b_win", win_b, eb.win);
        chk("b_latency", cyc, eb.done_cyc);
      end
    end
  end

  task automatic do_call(input logic [4:0] n, input logic [24:0] ec, input logic eh,
                         input logic [3:0] el, input bit push_b);
    exp_t e;
    int lo;
    int t;
    @(negedge clk);
    call_valid = 1'b1;
    call_num   = n;
    t = 0;
    while (!call_ready_a && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!call_ready_a) begin
      chk("call_ready_timeout", call_ready_a, 1'b1);
      call_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    call_valid = 1'b0;
    e.circle   = ec;
    e.hit      = eh;
    e.lines    = el;
    e.disp     = bcd8(el);
    e.win      = 1'b0;
    e.done_cyc = cyc + 26;
    qa.push_back(e);
    if (push_b) begin
      e.win = (el >= 4'd5);
      qb.push_back(e);
    end
    lo = 0;
    repeat (26) begin
      @(negedge clk);
      if (!call_ready_a) lo++;
    end
    chk("ready_low_cycles", lo, 26);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; clear = 1'b0; load_valid = 1'b0; load_num = '0;
    call_valid = 1'b0; call_num = '0;
    repeat (3) @(negedge clk);
    chk("rst_load_ready", load_ready_a, 1'b1);
    chk("rst_call_ready", call_ready_a, 1'b0);
    chk("rst_map", map_a, '0);
    chk("rst_circle", circle_a, '0);
    chk("rst_display", disp_a, '0);
    chk("rst_board_ready", board_ready_a, 1'b0);
    rst = 1'b1;

    // Cell i = i+1, with illegal values 0 and 30 interleaved.
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      if (i == 25) chk("board_ready_before_last", board_ready_a, 1'b0);
      load_valid = 1'b1; load_num = 5'(i);
      if (i % 6 == 0) begin @(negedge clk); load_num = 5'd0; end
      if (i % 7 == 0) begin @(negedge clk); load_num = 5'd30; end
    end
    @(negedge clk);
    load_valid = 1'b0;
    map_exp = '0;
    for (int i = 0; i < 25; i++) map_exp[5*i +: 5] = 5'(i + 1);
    chk("map_a", map_a, map_exp);
    chk("map_b", map_b, map_exp);
    chk("board_ready", board_ready_a, 1'b1);
    chk("call_ready_after_load", call_ready_a, 1'b1);
    chk("load_ready_after_load", load_ready_a, 1'b0);

    do_call(5'd13, 25'h0001000, 1'b1, 4'd0, 1'b1);
    do_call(5'd26, 25'h0001000, 1'b0, 4'd0, 1'b1);
    do_call(5'd13, 25'h0001000, 1'b1, 4'd0, 1'b1);

    for (int k = 1; k <= 25; k++) begin
      if (k > 21) chk("b_ready_after_win", call_ready_b, 1'b0);
      do_call(5'(k), 25'((32'd1 << k) - 32'd1) | 25'h0001000, 1'b1, 4'(lines_tab[k]), k <= 21);
    end

    // Clear lands on the edge ending scan index 10; the call must vanish.
    @(negedge clk);
    chk("ready_before_clear_call", call_ready_a, 1'b1);
    call_valid = 1'b1; call_num = 5'd7;
    @(posedge clk);
    #1 call_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    chk("clr_map", map_a, '0);
    chk("clr_circle", circle_a, '0);
    chk("clr_line_cnt", line_cnt_a, '0);
    chk("clr_display", disp_a, '0);
    chk("clr_load_ready", load_ready_a, 1'b1);
    chk("clr_call_ready", call_ready_a, 1'b0);
    chk("clr_board_ready", board_ready_a, 1'b0);
    chk("clr_call_hit", call_hit_a, 1'b0);
    chk("clr_win_b", win_b, 1'b0);
    repeat (40) @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      load_valid = 1'b1;
      load_num = (i == 0) ? 5'd5 : (i == 1) ? 5'd9 : 5'd17;
    end
    @(negedge clk);
    load_valid = 1'b0;
    chk("partial_load", map_a[14:0], {5'd17, 5'd9, 5'd5});
    #2 rst = 1'b0;
    #1;
    chk("arst_map", map_a, '0);
    chk("arst_load_ready", load_ready_a, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("queue_a_drained", qa.size(), 0);
    chk("queue_b_drained", qb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bingo_board_writer.md
# bingo_board_writer

Game-side writer that builds and maintains the 5x5 Bingo board state consumed by the VGA display path: the packed `map` of cell numbers, the `circle` mark vector, and the two-digit `display_nums` value shown on the seven-segment display. The board is first loaded one cell at a time. The block then accepts called numbers over a ready/valid handshake, scans all 25 cells sequentially to mark matches, and recounts completed lines (5 rows, 5 columns, 2 diagonals). It sits between game control / interboard logic and the display top, and is the sole writer of the display's board inputs.

## Interface
- `WIN_LINES`, default 5: number of completed lines that sets `win`.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous board clear; has priority over every other input.
- `load_valid`  in  1  `load_num` is valid.
- `load_num`  in  5  cell value to write at the current load pointer; legal range 1..25.
- `load_ready`  out  1  high in state LOAD.
- `call_valid`  in  1  `call_num` is valid.
- `call_num`  in  5  called number.
- `call_ready`  out  1  high in state PLAY while `win`=0.
- `call_done`  out  1  one-cycle pulse when a call completes.
- `call_hit`  out  1  at least one cell matched the last call; valid with `call_done`, held until the next `call_done`.
- `map`  out  125  cell i occupies bits [5i+4:5i]; i = x + 5y.
- `circle`  out  25  bit i set means cell i is marked.
- `line_cnt`  out  4  completed lines, 0..12.
- `display_nums`  out  8  BCD of `line_cnt`: {tens, ones}, range 8'h00..8'h12.
- `board_ready`  out  1  all 25 cells have been loaded.
- `win`  out  1  sticky; `line_cnt` >= `WIN_LINES`.

## Operation
- States: LOAD, PLAY, SCAN, COUNT.
- Reset, or `clear`=1 at a clock edge:
  - State goes to LOAD.
  - `map`, `circle`, `line_cnt`, `display_nums`, load pointer, scan index, `call_done`, `call_hit`, `board_ready` and `win` all go to 0.
  - A `clear` during SCAN or COUNT aborts the call; no `call_done` is issued.
- LOAD:
  - A load is accepted when `load_valid`=1 and `load_num` is in 1..25. The value is written to cell[ptr] and ptr increments.
  - A `load_num` of 0 or 26..31 is ignored: no write, pointer unchanged.
  - Accepting at ptr=24 moves the state to PLAY and sets `board_ready`=1.
  - Duplicate values are not checked; that is the caller's responsibility.
  - `call_valid` is ignored in LOAD.
- PLAY:
  - A call is accepted when `call_valid` and `call_ready` are both 1. `call_num` is latched, the internal hit flag is cleared, idx=0, and the state goes to SCAN.
  - `load_valid` is ignored.
- SCAN:
  - One cell per cycle, idx 0..24.
  - If cell[idx] equals the latched number: `circle[idx]` is set and the hit flag is set.
  - An already-marked cell that matches still counts as a hit; `circle` is never cleared outside reset/clear.
  - Every matching cell is marked, so duplicate cells are all marked.
  - After idx=24 the state goes to COUNT.
- COUNT:
  - One cycle: `line_cnt` is registered as the count of fully marked lines from `circle`, and `display_nums` is registered as its BCD.
  - Rows: cells 5y..5y+4. Columns: x, x+5, x+10, x+15, x+20. Diagonals: 0,6,12,18,24 and 4,8,12,16,20.
  - `win` is set if the new count >= `WIN_LINES`.
  - Next state is PLAY, with `call_done`=1 and `call_hit` = hit flag for one cycle.
- After `win`=1, `call_ready` stays 0 until reset or `clear`.
- `call_num` of 0 or above 25 is accepted, scans, never matches, and returns `call_hit`=0.

## Timing
- All outputs are registered. Reset values are all 0, except `load_ready`=1 because the reset state is LOAD.
- Load throughput is one cell per cycle. `board_ready` and `call_ready` rise on the edge that accepts the 25th cell.
- For a call accepted at edge E0:
  - SCAN covers idx0 after E0 through idx24 after E24.
  - COUNT follows E25.
  - `call_done`, `call_hit` and the updated `line_cnt`, `display_nums` and `win` are visible after E26.
- `call_ready` is 0 from E0 through E25 and returns to 1 with `call_done`. A new call may be accepted on the same edge that ends the `call_done` cycle.
- A `circle` bit becomes visible on the edge following its scan cycle.
- `clear` and `call_valid` asserted together: `clear` wins and the call is not accepted.

## Test plan
- Load with cell i = i+1, then call 13: `circle` = 25'h0001000, `call_hit`=1, `line_cnt`=0, and `call_done` arrives exactly 26 edges after acceptance.
- Same board, call 1,2,3,4,5: after the fifth `call_done`, `line_cnt`=1 and `display_nums`=8'h01; `call_ready` is low for 26 cycles per call.
- Same board, call 1..25 with `WIN_LINES`=13: `line_cnt`=12, `display_nums`=8'h12, `win`=0. Repeat with `WIN_LINES`=5: `win`=1 after the 5th completed line, then `call_ready` stays 0.
- Load sequence containing 0 and 30 interleaved with 1..25: the invalid values are skipped, `map` matches the valid sequence, and `board_ready` rises after the 25th valid value.
- Assert `clear` at SCAN idx 10: no `call_done`, all outputs 0, `load_ready`=1 on the next cycle. Assert `rst` low asynchronously mid-LOAD: outputs clear immediately, without waiting for a clock edge.
- Call 26, then call an already-circled number: 26 gives `call_hit`=0 with `circle` unchanged; the already-circled number gives `call_hit`=1 with `circle` and `line_cnt` unchanged.
